// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and baud divisor table.
// Used by uart_rx_byte (and the later uart_tx); no logic of its own.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;
   localparam int DIV_W           = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

   // round(clk_hz / (baud * 16)); codes: 00=100000, 01=9600, 10=57600, 11=115200
   function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz, input logic [1:0] sel);
      int unsigned baud;
      case (sel)
         2'b00:   baud = 100000;
         2'b01:   baud = 9600;
         2'b10:   baud = 57600;
         default: baud = 115200;
      endcase
      return DIV_W'((clk_hz + baud * 8) / (baud * 16));
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..div-1 counter, tick on the wrap, clear realigns phase.
// Tick is combinational from the counter (zero latency); no backpressure.
module uart_baud_tick
   import uart_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = !clear && (cnt == div - DIV_W'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + DIV_W'(1);
   end

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver, 8N1 16x oversampled (even parity bit + parity_err when UART_RX_PARITY_EN is defined).
// rx_valid/rx_frame_err pulse 1 clock after the mid-stop sample (+2 clk sync); no backpressure.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx_serial,
   input  logic [1:0]           baudrate_sel,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 rx_busy
);

   localparam int         BCW      = $clog2(DATA_BITS);
   localparam logic [3:0] SMP_MID  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);

   logic                 sync_0, rxs;
   rx_state_t            state, state_nxt;
   logic [DIV_W-1:0]     div_q;
   logic                 tick;
   logic [3:0]           samp_cnt;
   logic [BCW-1:0]       bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 start_det, smp_rst, shift_en, load, ferr;
`ifdef UART_RX_PARITY_EN
   logic                 par_chk, par_bad;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_0 <= 1'b1;
         rxs    <= 1'b1;
      end else begin
         sync_0 <= rx_serial;
         rxs    <= sync_0;
      end
   end

   uart_baud_tick u_tick (
      .clock (clock),
      .reset (reset),
      .clear (start_det),
      .div   (div_q),
      .tick  (tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_det = 1'b0;
      smp_rst   = 1'b0;
      shift_en  = 1'b0;
      load      = 1'b0;
      ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk   = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (!rxs) begin
               start_det = 1'b1;
               state_nxt = ST_START;
            end
         end
         // Mid start bit: a line back high here was a glitch, not a frame.
         ST_START: begin
            if (tick && samp_cnt == SMP_MID) begin
               smp_rst   = 1'b1;
               state_nxt = rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick && samp_cnt == SMP_LAST) begin
               shift_en = 1'b1;
               if (bit_cnt == BCW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick && samp_cnt == SMP_LAST) begin
               par_chk   = 1'b1;
               state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tick && samp_cnt == SMP_LAST) begin
               if (rxs) begin
                  load      = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  ferr      = 1'b1;
                  state_nxt = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rxs)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Rate code is captured only at start detect so mid-frame changes cannot corrupt a frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_q    <= baud_div(CLK_HZ, 2'b00);
         samp_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         if (start_det)
            div_q <= baud_div(CLK_HZ, baudrate_sel);
         if (start_det || smp_rst)
            samp_cnt <= '0;
         else if (tick)
            samp_cnt <= samp_cnt + 4'd1;
         if (start_det)
            bit_cnt <= '0;
         else if (shift_en)
            bit_cnt <= bit_cnt + BCW'(1);
         if (shift_en)
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_valid     <= load;
         rx_frame_err <= ferr;
         if (load)
            rx_data <= shreg;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Even parity: data ones plus the parity bit must total an even count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (par_chk)
            par_bad <= (^shreg) ^ rxs;
         parity_err <= load & par_bad;
      end
   end
`endif

   assign rx_busy = (state != ST_IDLE);

endmodule
